// File: rtl/direction_input_ctrl.sv
// Push-button front end for the 2048 core: sync, debounce, one-hot command per press.
// Optional auto-repeat of a held direction is compiled in with `define DIR_AUTO_REPEAT_EN.
module direction_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [1:0] game_state,
  output logic [3:0] direction,
  output logic       cmd_pending
);

  // state           | meaning
  // ST_WAIT_READY   | no command; wait for playing with all buttons released
  // ST_ARMED        | no command; accept the next single debounced press
  // ST_WAIT_ACK     | command held until the core leaves playing
  // ST_WAIT_RELEASE | no command; wait for all buttons released (or auto-repeat)
  localparam logic [1:0] ST_WAIT_READY   = 2'd0;
  localparam logic [1:0] ST_ARMED        = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK     = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic RELEASED_LVL = BTN_ACTIVE_LOW;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("direction_input_ctrl: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [3:0] btn_raw;
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;
  logic [3:0] btn_norm;
  logic [3:0] press_vec;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= {4{RELEASED_LVL}};
      sync_q2 <= {4{RELEASED_LVL}};
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_norm = BTN_ACTIVE_LOW ? ~sync_q2 : sync_q2;

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [DB_W-1:0] cnt_q;
    logic            lvl_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (btn_norm[i] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_q <= '0;
        lvl_q <= btn_norm[i];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign press_vec[i] = lvl_q;
  end

  logic       playing;
  logic       press_none;
  logic       press_one_hot;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] dir_q;
  logic [3:0] dir_d;

  assign playing       = (game_state == 2'b01);
  assign press_none    = (press_vec == 4'b0000);
  assign press_one_hot = !press_none && ((press_vec & (press_vec - 4'd1)) == 4'b0000);

`ifdef DIR_AUTO_REPEAT_EN
  localparam int unsigned RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [3:0]      last_dir_q;
  logic [3:0]      last_dir_d;
  logic [RP_W-1:0] rpt_cnt_q;
  logic            rpt_hold;
  logic            rpt_fire;

  // Only the exact direction last issued may repeat; any other pattern restarts the wait.
  assign rpt_hold = (state_q == ST_WAIT_RELEASE) && (last_dir_q != 4'b0000) &&
                    (press_vec == last_dir_q);
  assign rpt_fire = rpt_hold && (rpt_cnt_q == '0) && playing;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q  <= RP_LAST;
      last_dir_q <= 4'b0000;
    end else begin
      last_dir_q <= last_dir_d;
      if (!rpt_hold || rpt_fire) begin
        rpt_cnt_q <= RP_LAST;
      end else if (rpt_cnt_q != '0) begin
        rpt_cnt_q <= rpt_cnt_q - 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
`ifdef DIR_AUTO_REPEAT_EN
    last_dir_d = last_dir_q;
`endif
    case (state_q)
      ST_WAIT_READY: begin
        dir_d = 4'b0000;
        if (playing && press_none) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        dir_d = 4'b0000;
        if (!playing) begin
          state_d = ST_WAIT_READY;
        end else if (press_one_hot) begin
          dir_d   = press_vec;
          state_d = ST_WAIT_ACK;
`ifdef DIR_AUTO_REPEAT_EN
          last_dir_d = press_vec;
`endif
        end else if (!press_none) begin
          state_d = ST_WAIT_RELEASE;
`ifdef DIR_AUTO_REPEAT_EN
          last_dir_d = 4'b0000;
`endif
        end
      end
      ST_WAIT_ACK: begin
        if (!playing) begin
          dir_d   = 4'b0000;
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        dir_d = 4'b0000;
        if (press_none) begin
          state_d = ST_WAIT_READY;
`ifdef DIR_AUTO_REPEAT_EN
        end else if (rpt_fire) begin
          dir_d   = last_dir_q;
          state_d = ST_WAIT_ACK;
`endif
        end
      end
      default: begin
        dir_d   = 4'b0000;
        state_d = ST_WAIT_READY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WAIT_READY;
      dir_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  assign direction   = dir_q;
  assign cmd_pending = |dir_q;

endmodule
